// File: rtl/st506_seek_controller.sv
`default_nettype none
// ============================================================================
// Module   : st506_seek_controller
// Purpose  : Multi-drive ST-506 seek/recalibrate sequencer. Tracks each
//            drive's cylinder and calibration flag, and generates timed
//            STEP/DIRECTION sequences in normal or buffered step mode. It then
//            waits for SEEK COMPLETE with a timeout and reports a status code.
// Revision : 1.0 - initial release
// ============================================================================
module st506_seek_controller #(
    parameter int NUM_DRIVES = 4,
    parameter int CYL_WIDTH  = 11,
    parameter int DIR_SETUP  = 300,
    parameter int STEP_HOLD  = 300,
    parameter int RECAL_MAX  = 1024,
    localparam int DW = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_recal,
    input  logic [DW-1:0]        cmd_drive,
    input  logic [CYL_WIDTH-1:0] cmd_cyl,
    input  logic                 buffered_mode,
    input  logic [15:0]          step_pulse_width,
    input  logic [15:0]          step_period,
    input  logic [15:0]          buf_period,
    input  logic [31:0]          timeout_cycles,
    input  logic                 seek_complete,
    input  logic                 at_track00,
    output logic                 step_pulse,
    output logic                 step_dir,
    output logic [DW-1:0]        active_drive,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           err_code,
    input  logic [DW-1:0]        query_drive,
    output logic [CYL_WIDTH-1:0] cyl_out,
    output logic                 cyl_valid_out
);

    // Phase lengths below one cycle are stretched to one so every phase is observable.
    localparam int                   c_rcw        = $clog2(RECAL_MAX + 1);
    localparam logic [31:0]          c_setup_last = (DIR_SETUP > 1) ? 32'(DIR_SETUP - 1) : 32'd0;
    localparam logic [31:0]          c_hold_last  = (STEP_HOLD > 1) ? 32'(STEP_HOLD - 1) : 32'd0;
    localparam logic [c_rcw-1:0]     c_recal_max  = c_rcw'(RECAL_MAX);
    localparam logic [c_rcw-1:0]     c_rc_one     = c_rcw'(1);
    localparam logic [CYL_WIDTH-1:0] c_cyl_max    = '1;
    localparam logic [CYL_WIDTH-1:0] c_cyl_one    = CYL_WIDTH'(1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_setup  = 3'd1;
    localparam logic [2:0] c_st_pulse  = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_gap    = 3'd4;
    localparam logic [2:0] c_st_settle = 3'd5;

    logic [2:0]            r_state;
    logic [31:0]           r_cnt;
    logic [DW-1:0]         r_drive;
    logic                  r_recal;
    logic [CYL_WIDTH-1:0]  r_remaining;
    logic [c_rcw-1:0]      r_recal_cnt;
    logic [15:0]           r_width;
    logic [15:0]           r_gap;
    logic [31:0]           r_timeout;
    logic                  r_step_pulse;
    logic                  r_step_dir;
    logic                  r_done;
    logic [1:0]            r_err;
    logic [CYL_WIDTH-1:0]  r_cyl [NUM_DRIVES];
    logic [NUM_DRIVES-1:0] r_valid;

    logic                  w_phase_end;
    logic                  w_gap_end;
    logic [CYL_WIDTH-1:0]  w_cur_cyl;
    logic                  w_cur_valid;
    logic [CYL_WIDTH-1:0]  w_diff;
    logic [CYL_WIDTH-1:0]  w_step_cyl;
    logic [15:0]           w_width_in;
    logic [15:0]           w_gap_in;

    assign w_cur_cyl   = r_cyl[cmd_drive];
    assign w_cur_valid = r_valid[cmd_drive];
    assign w_diff      = (cmd_cyl > w_cur_cyl) ? (cmd_cyl - w_cur_cyl) : (w_cur_cyl - cmd_cyl);
    assign w_width_in  = (step_pulse_width == 16'd0) ? 16'd1 : step_pulse_width;
    // Recalibration always uses the normal step rate; buffered mode only speeds up seeks.
    assign w_gap_in    = (cmd_recal || !buffered_mode) ? step_period : buf_period;

    // Detect the last cycle of the current timed phase.
    always_comb begin
        w_phase_end = 1'b0;
        case (r_state)
            c_st_setup: w_phase_end = (r_cnt == c_setup_last);
            c_st_pulse: w_phase_end = (r_cnt == {16'd0, r_width - 16'd1});
            c_st_hold:  w_phase_end = (r_cnt == c_hold_last);
            c_st_gap:   w_phase_end = (r_cnt == {16'd0, r_gap - 16'd1});
            default:    w_phase_end = 1'b0;
        endcase
    end

    // A zero-length gap ends together with the hold phase.
    assign w_gap_end = w_phase_end &&
                       ((r_state == c_st_gap) || ((r_state == c_st_hold) && (r_gap == 16'd0)));

    // Cylinder after one step in the current direction, clamped at both ends.
    always_comb begin
        w_step_cyl = r_cyl[r_drive];
        if (r_step_dir) begin
            if (r_cyl[r_drive] != c_cyl_max) w_step_cyl = r_cyl[r_drive] + c_cyl_one;
        end else begin
            if (r_cyl[r_drive] != '0) w_step_cyl = r_cyl[r_drive] - c_cyl_one;
        end
    end

    // Command sequencer, per-drive position tracking and status reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_cnt        <= '0;
            r_drive      <= '0;
            r_recal      <= 1'b0;
            r_remaining  <= '0;
            r_recal_cnt  <= '0;
            r_width      <= 16'd1;
            r_gap        <= '0;
            r_timeout    <= '0;
            r_step_pulse <= 1'b0;
            r_step_dir   <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 2'b00;
            r_valid      <= '0;
            for (int i = 0; i < NUM_DRIVES; i++) begin
                r_cyl[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cmd_valid) begin
                        r_drive     <= cmd_drive;
                        r_recal     <= cmd_recal;
                        r_width     <= w_width_in;
                        r_gap       <= w_gap_in;
                        r_timeout   <= timeout_cycles;
                        r_err       <= 2'b00;
                        r_cnt       <= '0;
                        r_recal_cnt <= '0;
                        if (cmd_recal) begin
                            r_step_dir <= 1'b0;
                            if (at_track00) begin
                                r_cyl[cmd_drive]   <= '0;
                                r_valid[cmd_drive] <= 1'b1;
                                r_state            <= c_st_settle;
                            end else begin
                                r_valid[cmd_drive] <= 1'b0;
                                r_state            <= c_st_setup;
                            end
                        end else if (!w_cur_valid) begin
                            r_done <= 1'b1;
                            r_err  <= 2'b11;
                        end else if (cmd_cyl == w_cur_cyl) begin
                            r_done <= 1'b1;
                        end else begin
                            r_step_dir  <= (cmd_cyl > w_cur_cyl);
                            r_remaining <= w_diff;
                            r_state     <= c_st_setup;
                        end
                    end
                end
                c_st_setup: begin
                    if (w_phase_end) begin
                        r_cnt          <= '0;
                        r_step_pulse   <= 1'b1;
                        r_cyl[r_drive] <= w_step_cyl;
                        if (r_recal) r_recal_cnt <= r_recal_cnt + c_rc_one;
                        else         r_remaining <= r_remaining - c_cyl_one;
                        r_state        <= c_st_pulse;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_st_pulse: begin
                    if (w_phase_end) begin
                        r_cnt        <= '0;
                        r_step_pulse <= 1'b0;
                        r_state      <= c_st_hold;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_st_hold: begin
                    if (w_phase_end) begin
                        r_cnt   <= '0;
                        r_state <= c_st_gap;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_st_gap: begin
                    if (!w_phase_end) r_cnt <= r_cnt + 32'd1;
                end
                c_st_settle: begin
                    if (seek_complete) begin
                        r_done  <= 1'b1;
                        r_err   <= 2'b00;
                        r_state <= c_st_idle;
                    end else if (r_cnt >= r_timeout) begin
                        r_done           <= 1'b1;
                        r_err            <= 2'b01;
                        r_valid[r_drive] <= 1'b0;
                        r_state          <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            // End of an inter-step gap: decide whether to step again, settle or give up.
            // Track 0 is checked before the step budget so the last allowed step can still succeed.
            if (w_gap_end) begin
                r_cnt <= '0;
                if (!r_recal) begin
                    r_state <= (r_remaining != '0) ? c_st_setup : c_st_settle;
                end else if (at_track00) begin
                    r_cyl[r_drive]   <= '0;
                    r_valid[r_drive] <= 1'b1;
                    r_state          <= c_st_settle;
                end else if (r_recal_cnt == c_recal_max) begin
                    r_done  <= 1'b1;
                    r_err   <= 2'b10;
                    r_state <= c_st_idle;
                end else begin
                    r_state <= c_st_setup;
                end
            end
        end
    end

    assign cmd_ready     = (r_state == c_st_idle);
    assign busy          = (r_state != c_st_idle);
    assign step_pulse    = r_step_pulse;
    assign step_dir      = r_step_dir;
    assign active_drive  = r_drive;
    assign done          = r_done;
    assign err_code      = r_err;
    assign cyl_out       = r_cyl[query_drive];
    assign cyl_valid_out = r_valid[query_drive];

endmodule
`default_nettype wire

// File: tb/tb_st506_seek_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_st506_seek_controller
// Purpose  : Self-checking bench for st506_seek_controller. A physical head
//            model per drive drives at_track00; expected timing and status come
//            from closed-form arithmetic on the command parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_st506_seek_controller;

    localparam int c_ds   = 2;
    localparam int c_sh   = 2;
    localparam int c_rmax = 8;
    localparam int c_budget = 3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_recal = 1'b0;
    logic [1:0]  cmd_drive = '0;
    logic [10:0] cmd_cyl = '0;
    logic        buffered_mode = 1'b0;
    logic [15:0] step_pulse_width = 16'd1;
    logic [15:0] step_period = 16'd1;
    logic [15:0] buf_period = 16'd1;
    logic [31:0] timeout_cycles = 32'd0;
    logic        seek_complete = 1'b0;
    logic        at_track00;
    logic        step_pulse;
    logic        step_dir;
    logic [1:0]  active_drive;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [1:0]  query_drive = '0;
    logic [10:0] cyl_out;
    logic        cyl_valid_out;

    // Reference state: believed cylinder/flag per drive, and true head positions.
    int m_cyl   [4] = '{0, 0, 0, 0};
    bit m_valid [4] = '{0, 0, 0, 0};
    int head    [4] = '{0, 3, 20, 5};
    int cur_drive = 0;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int rise_q[$];
    int width_q[$];
    bit dir_q[$];
    bit prev_sp = 1'b0;
    int cur_w = 0;

    assign at_track00 = (head[cur_drive] == 0);

    st506_seek_controller #(
        .NUM_DRIVES(4), .CYL_WIDTH(11), .DIR_SETUP(c_ds), .STEP_HOLD(c_sh), .RECAL_MAX(c_rmax)
    ) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_recal(cmd_recal), .cmd_drive(cmd_drive), .cmd_cyl(cmd_cyl),
        .buffered_mode(buffered_mode), .step_pulse_width(step_pulse_width),
        .step_period(step_period), .buf_period(buf_period), .timeout_cycles(timeout_cycles),
        .seek_complete(seek_complete), .at_track00(at_track00), .step_pulse(step_pulse),
        .step_dir(step_dir), .active_drive(active_drive), .busy(busy), .done(done),
        .err_code(err_code), .query_drive(query_drive), .cyl_out(cyl_out),
        .cyl_valid_out(cyl_valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the step line: record rise cycles, directions, widths, and move the head.
    always @(negedge clk) begin
        if (step_pulse) begin
            if (!prev_sp) begin
                rise_q.push_back(cyc);
                dir_q.push_back(step_dir);
                cur_w = 1;
                if (step_dir) head[cur_drive] = head[cur_drive] + 1;
                else if (head[cur_drive] > 0) head[cur_drive] = head[cur_drive] - 1;
            end else begin
                cur_w = cur_w + 1;
            end
        end else if (prev_sp) begin
            width_q.push_back(cur_w);
        end
        prev_sp = step_pulse;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_drive_state(input int d);
        query_drive = 2'(d);
        #1;
        chk("cyl_out", 32'(cyl_out), 32'(m_cyl[d]));
        chk("cyl_valid", 32'(cyl_valid_out), 32'(m_valid[d]));
    endtask

    task automatic run_cmd(input bit recal, input int drv, input int tgt, input bit bufm,
                           input int width, input int per, input int bper, input int tmo,
                           input bit sc);
        int a, n, w, gap, p, first, s, exp_done, old, waited, lim;
        int exp_err;
        bit exp_dir, settle;
        @(negedge clk);
        chk("ready_before", 32'(cmd_ready), 32'd1);
        cur_drive        = drv;
        cmd_valid        = 1'b1;
        cmd_recal        = recal;
        cmd_drive        = 2'(drv);
        cmd_cyl          = 11'(tgt);
        buffered_mode    = bufm;
        step_pulse_width = 16'(width);
        step_period      = 16'(per);
        buf_period       = 16'(bper);
        timeout_cycles   = 32'(tmo);
        seek_complete    = sc;
        rise_q.delete();
        dir_q.delete();
        width_q.delete();
        a = cyc;

        w   = (width == 0) ? 1 : width;
        gap = recal ? per : (bufm ? bper : per);
        p   = c_ds + w + c_sh + gap;
        n = 0; settle = 0; exp_dir = 0; exp_err = 0;
        if (recal) begin
            old = m_cyl[drv];
            n = (head[drv] < c_rmax) ? head[drv] : c_rmax;
            if (head[drv] > c_rmax) begin
                exp_err      = 2;
                m_valid[drv] = 0;
                m_cyl[drv]   = (old > n) ? old - n : 0;
            end else begin
                settle       = 1;
                m_cyl[drv]   = 0;
                m_valid[drv] = 1;
            end
        end else if (!m_valid[drv]) begin
            exp_err = 3;
        end else if (tgt != m_cyl[drv]) begin
            exp_dir    = (tgt > m_cyl[drv]);
            n          = exp_dir ? tgt - m_cyl[drv] : m_cyl[drv] - tgt;
            settle     = 1;
            m_cyl[drv] = tgt;
        end
        first = a + 1 + c_ds;
        s = (n == 0) ? a + 1 : first + (n - 1) * p + w + c_sh + gap;
        if (settle) begin
            if (sc) begin exp_err = 0; exp_done = s + 1; end
            else begin exp_err = 1; exp_done = s + tmo + 1; m_valid[drv] = 0; end
        end else if (exp_err == 2) begin
            exp_done = s;
        end else begin
            exp_done = a + 1;
        end

        @(negedge clk);
        cmd_valid        = 1'b0;
        cmd_cyl          = 11'($urandom);
        cmd_drive        = 2'($urandom);
        cmd_recal        = 1'($urandom);
        buffered_mode    = 1'($urandom);
        step_pulse_width = 16'($urandom_range(0, 9));
        step_period      = 16'($urandom_range(0, 30));
        buf_period       = 16'($urandom_range(0, 30));
        timeout_cycles   = 32'($urandom_range(0, 90));
        waited = 0;
        while (!done && waited < c_budget) begin
            @(negedge clk);
            waited++;
        end
        if (!done) chk("done_within_budget", 32'd0, 32'd1);
        chk("done_cycle", 32'(cyc), 32'(exp_done));
        chk("err_code", 32'(err_code), 32'(exp_err));
        chk("ready_at_done", 32'(cmd_ready), 32'd1);
        chk("active_drive", 32'(active_drive), 32'(drv));
        chk("pulse_count", 32'(rise_q.size()), 32'(n));
        lim = (rise_q.size() < n) ? rise_q.size() : n;
        for (int i = 0; i < lim; i++) begin
            chk("rise_cycle", 32'(rise_q[i]), 32'(first + i * p));
            chk("step_dir", 32'(dir_q[i]), 32'(recal ? 1'b0 : exp_dir));
            if (i < width_q.size()) chk("pulse_width", 32'(width_q[i]), 32'(w));
        end
        check_drive_state(drv);
    endtask

    initial begin
        int waited;
        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_step_pulse", 32'(step_pulse), 32'd0);
        chk("rst_step_dir", 32'(step_dir), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err_code), 32'd0);
        chk("rst_active_drive", 32'(active_drive), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) check_drive_state(d);

        // Directed scenarios.
        run_cmd(0, 0, 5, 0, 1, 4, 1, 10, 1);     // uncalibrated seek
        run_cmd(1, 1, 0, 0, 1, 4, 1, 10, 1);     // recal, track 0 after 3 steps
        run_cmd(0, 1, 7, 0, 3, 10, 1, 10, 1);    // 0 -> 7, spacing 17
        run_cmd(0, 1, 4, 0, 3, 10, 1, 10, 1);    // 7 -> 4 outward
        run_cmd(0, 1, 4, 0, 3, 10, 1, 10, 1);    // already there
        run_cmd(0, 1, 0, 0, 2, 5, 1, 10, 1);
        run_cmd(0, 1, 4, 1, 3, 99, 1, 10, 1);    // buffered, spacing 8
        run_cmd(1, 2, 0, 0, 1, 3, 1, 10, 1);     // track 0 never found
        run_cmd(1, 0, 0, 0, 1, 3, 1, 10, 1);     // already at track 0
        run_cmd(0, 0, 6, 0, 2, 4, 1, 50, 0);     // settle timeout
        run_cmd(1, 3, 0, 0, 0, 0, 1, 0, 0);      // zero gap, zero timeout

        // Reset in the middle of a step pulse.
        run_cmd(1, 0, 0, 0, 1, 3, 1, 10, 1);
        @(negedge clk);
        cur_drive = 0; cmd_valid = 1'b1; cmd_recal = 1'b0; cmd_drive = 2'd0; cmd_cyl = 11'd10;
        step_pulse_width = 16'd4; step_period = 16'd3; seek_complete = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        waited = 0;
        while (!step_pulse && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("pulse_before_reset", 32'(step_pulse), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async_pulse", 32'(step_pulse), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            m_cyl[d] = 0;
            m_valid[d] = 0;
        end
        for (int d = 0; d < 4; d++) check_drive_state(d);
        run_cmd(0, 0, 5, 0, 1, 4, 1, 10, 1);

        // Randomized command stream.
        for (int i = 0; i < 40; i++) begin
            run_cmd(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 30),
                    1'($urandom), $urandom_range(0, 4), $urandom_range(0, 10),
                    $urandom_range(0, 6), $urandom_range(0, 20), ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
